// File: rtl/div_restoring_seq.sv
`default_nettype none
// ============================================================================
// Module   : div_restoring_seq
// Brief    : Sequential restoring divider, one quotient bit per clock, with a
//            start/done handshake. Optional signed mode via DIV_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module div_restoring_seq #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] Q,
    output logic [W-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         DZ,
    output logic         V
);

    localparam int c_CW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_p;
    logic [c_CW-1:0] r_cnt;
    logic [W-1:0]    r_q;
    logic [W-1:0]    r_r;
    logic            r_dz;

    logic            w_accept;
    logic            w_bzero;
    logic [W-1:0]    w_a_mag;
    logic [W-1:0]    w_b_mag;
    logic [W:0]      w_shift;
    logic [W+1:0]    w_trial;
    logic            w_qbit;
    logic [W-1:0]    w_p_nxt;
    logic [W-1:0]    w_q_mag;
    logic [W-1:0]    w_q_res;
    logic [W-1:0]    w_r_res;

    assign w_accept = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_bzero  = (B == '0);

    // Trial subtract carried one bit wider so the sign of P - B is explicit.
    assign w_shift  = {r_p, r_a[W-1]};
    assign w_trial  = {1'b0, w_shift} - {2'b00, r_b};
    assign w_qbit   = (w_trial[W+1:W] == 2'b00);
    assign w_p_nxt  = w_qbit ? w_trial[W-1:0] : w_shift[W-1:0];
    assign w_q_mag  = {r_a[W-2:0], w_qbit};

`ifdef DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;
    logic r_ovf;
    logic r_v;
    logic w_ovf;

    assign w_a_mag = A[W-1] ? (~A + 1'b1) : A;
    assign w_b_mag = B[W-1] ? (~B + 1'b1) : B;
    assign w_ovf   = (A == {1'b1, {(W-1){1'b0}}}) && (B == '1);
    assign w_q_res = r_neg_q ? (~w_q_mag + 1'b1) : w_q_mag;
    assign w_r_res = r_neg_r ? (~w_p_nxt + 1'b1) : w_p_nxt;
    assign V       = r_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_ovf   <= 1'b0;
            r_v     <= 1'b0;
        end else if (w_accept) begin
            if (w_bzero) begin
                r_v <= 1'b0;
            end else begin
                r_neg_q <= A[W-1] ^ B[W-1];
                r_neg_r <= A[W-1];
                r_ovf   <= w_ovf;
            end
        end else if ((r_state == S_CALC) && (r_cnt == '0)) begin
            r_v <= r_ovf;
        end
    end
`else
    assign w_a_mag = A;
    assign w_b_mag = B;
    assign w_q_res = w_q_mag;
    assign w_r_res = w_p_nxt;
    assign V       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = w_bzero ? S_DONE : S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_cnt == '0) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) w_state_nxt = w_bzero ? S_DONE : S_CALC;
                else       w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // r_a doubles as dividend shifter and quotient accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_p   <= '0;
            r_cnt <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_dz  <= 1'b0;
        end else if (w_accept) begin
            if (w_bzero) begin
                r_q  <= '1;
                r_r  <= A;
                r_dz <= 1'b1;
            end else begin
                r_a   <= w_a_mag;
                r_b   <= w_b_mag;
                r_p   <= '0;
                r_cnt <= c_CW'(W - 1);
            end
        end else if (r_state == S_CALC) begin
            r_a <= w_q_mag;
            r_p <= w_p_nxt;
            if (r_cnt == '0) begin
                r_q  <= w_q_res;
                r_r  <= w_r_res;
                r_dz <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign Q  = r_q;
    assign R  = r_r;
    assign DZ = r_dz;

endmodule
`default_nettype wire
